// File: rtl/reg_file_slave.sv
// ----------------------------------------------------------------------------
// reg_file_slave
//
// Bus-side slave register file. It holds six 16-bit general registers
// (R0-R5), a 16-bit write counter (WCNT) with a sticky wrap flag (OVF), and a
// read-only status word. Reads are answered with a registered response one
// cycle after the request edge.
//
// Address map:
//   0-5 : R0-R5, read/write
//   6   : WCNT; a write clears WCNT and OVF, and the write data is ignored
//   7   : STATUS = {15'b0, OVF}, read-only (writes are dropped)
//
// Ports:
//   clk      - system clock, rising-edge active
//   reset_n  - asynchronous active-low reset
//   s_sel    - slave select; a transaction is accepted in any cycle it is high
//   s_wr     - 1 = write, 0 = read
//   s_addr   - register address (3 bits)
//   s_din    - write data (16 bits)
//   s_dout   - read data; zero whenever s_rvalid is low
//   s_rvalid - one-cycle read response strobe
// ----------------------------------------------------------------------------
module reg_file_slave (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [2:0]  s_addr,
    input  logic [15:0] s_din,
    output logic [15:0] s_dout,
    output logic        s_rvalid
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] gpr_q [6];
    logic [15:0] gpr_d [6];
    logic [15:0] wcnt_q, wcnt_d;
    logic        ovf_q, ovf_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] read_mux;

    // Combinational view of the addressed register, as it stands before this
    // cycle's edge. Reads and writes are exclusive within a cycle, so no
    // write-forwarding is needed.
    always_comb begin
        read_mux = 16'h0000;
        case (s_addr)
            3'd0:    read_mux = gpr_q[0];
            3'd1:    read_mux = gpr_q[1];
            3'd2:    read_mux = gpr_q[2];
            3'd3:    read_mux = gpr_q[3];
            3'd4:    read_mux = gpr_q[4];
            3'd5:    read_mux = gpr_q[5];
            3'd6:    read_mux = wcnt_q;
            default: read_mux = {15'b0, ovf_q};
        endcase
    end

    // Next-state logic for the storage and the response FSM. The FSM leaves
    // RESP unless another read is accepted in the same cycle, which lets
    // back-to-back reads keep s_rvalid high continuously.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;
        rdata_d = rdata_q;
        state_d = IDLE;

        if (s_sel && s_wr) begin
            if (s_addr < 3'd6) begin
                gpr_d[s_addr] = s_din;
                wcnt_d        = wcnt_q + 16'd1;
                // OVF is sticky: it is only cleared by a write to WCNT.
                if (wcnt_q == 16'hFFFF) begin
                    ovf_d = 1'b1;
                end
            end else if (s_addr == 3'd6) begin
                wcnt_d = 16'h0000;
                ovf_d  = 1'b0;
            end
        end else if (s_sel) begin
            rdata_d = read_mux;
            state_d = RESP;
        end
    end

    // State registers. An asynchronous reset drops any pending response at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 6; i++) begin
                gpr_q[i] <= 16'h0000;
            end
            wcnt_q  <= 16'h0000;
            ovf_q   <= 1'b0;
            rdata_q <= 16'h0000;
            state_q <= IDLE;
        end else begin
            for (int i = 0; i < 6; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            state_q <= state_d;
        end
    end

    // Outputs are forced to zero outside RESP, so stale read data never leaks.
    always_comb begin
        s_rvalid = (state_q == RESP);
        s_dout   = (state_q == RESP) ? rdata_q : 16'h0000;
    end

endmodule

// File: tb/tb_reg_file_slave.sv
// ----------------------------------------------------------------------------
// tb_reg_file_slave
//
// Self-checking bench for reg_file_slave. A small reference model of the
// register file supplies the expected read data. Each read pushes its
// expected value onto a scoreboard queue, and each response is popped from
// that queue and compared.
// ----------------------------------------------------------------------------
module tb_reg_file_slave;

    logic        clk;
    logic        reset_n;
    logic        s_sel;
    logic        s_wr;
    logic [2:0]  s_addr;
    logic [15:0] s_din;
    logic [15:0] s_dout;
    logic        s_rvalid;

    int total;
    int bad;

    logic [15:0] m_gpr [6];
    logic [15:0] m_wcnt;
    logic        m_ovf;
    logic [15:0] exp_q [$];

    reg_file_slave dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_sel    (s_sel),
        .s_wr     (s_wr),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .s_dout   (s_dout),
        .s_rvalid (s_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] model_read(input logic [2:0] addr);
        if (addr < 3'd6) return m_gpr[addr];
        if (addr == 3'd6) return m_wcnt;
        return {15'b0, m_ovf};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_gpr[i] = 16'h0000;
        m_wcnt = 16'h0000;
        m_ovf  = 1'b0;
    endtask

    task automatic model_write(input logic [2:0] addr, input logic [15:0] din);
        if (addr < 3'd6) begin
            m_gpr[addr] = din;
            if (m_wcnt == 16'hFFFF) m_ovf = 1'b1;
            m_wcnt = m_wcnt + 16'd1;
        end else if (addr == 3'd6) begin
            m_wcnt = 16'h0000;
            m_ovf  = 1'b0;
        end
    endtask

    // Drives one bus cycle at the falling edge, updates the model, and returns
    // 1 time unit after the rising edge that samples the request.
    task automatic drive(input logic sel, input logic wr, input logic [2:0] addr,
                         input logic [15:0] din);
        @(negedge clk);
        s_sel  = sel;
        s_wr   = wr;
        s_addr = addr;
        s_din  = din;
        if (sel && !wr) exp_q.push_back(model_read(addr));
        if (sel && wr)  model_write(addr, din);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset_n = 1'b0;
        s_sel = 1'b0; s_wr = 1'b0; s_addr = 3'd0; s_din = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (s_rvalid !== 1'b0 || s_dout !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: got rvalid=%b dout=%h, required rvalid=0 dout=0000", s_rvalid, s_dout);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 1'b0, a[2:0], 16'h0000);
            e = exp_q.pop_front();
            total++;
            if (s_rvalid !== 1'b1 || s_dout !== e) begin
                bad++;
                $display("FAIL reset_read[%0d]: got rvalid=%b dout=%h, required rvalid=1 dout=%h", a, s_rvalid, s_dout, e);
            end
            drive(1'b0, 1'b0, 3'd0, 16'h0000);
            total++;
            if (s_rvalid !== 1'b0 || s_dout !== 16'h0000) begin
                bad++;
                $display("FAIL reset_pulse[%0d]: got rvalid=%b dout=%h, required rvalid=0 dout=0000", a, s_rvalid, s_dout);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] e;
        drive(1'b1, 1'b1, 3'd3, 16'hA5A5);
        drive(1'b1, 1'b0, 3'd3, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_rvalid !== 1'b1 || s_dout !== 16'hA5A5 || e !== 16'hA5A5) begin
            bad++;
            $display("FAIL write_read_r3: got rvalid=%b dout=%h, required rvalid=1 dout=a5a5", s_rvalid, s_dout);
        end
        drive(1'b1, 1'b0, 3'd6, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_rvalid !== 1'b1 || s_dout !== 16'h0001 || e !== 16'h0001) begin
            bad++;
            $display("FAIL write_read_wcnt: got rvalid=%b dout=%h, required rvalid=1 dout=0001", s_rvalid, s_dout);
        end
        // A write immediately after a read must not alter the pending response.
        drive(1'b1, 1'b0, 3'd3, 16'h0000);
        e = exp_q.pop_front();
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = 3'd3; s_din = 16'h1234;
        model_write(3'd3, 16'h1234);
        total++;
        if (s_rvalid !== 1'b1 || s_dout !== e) begin
            bad++;
            $display("FAIL read_then_write: got rvalid=%b dout=%h, required rvalid=1 dout=%h", s_rvalid, s_dout, e);
        end
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'd3, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_rvalid !== 1'b1 || s_dout !== 16'h1234 || e !== 16'h1234) begin
            bad++;
            $display("FAIL read_after_write: got rvalid=%b dout=%h, required rvalid=1 dout=1234", s_rvalid, s_dout);
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, i[2:0], 16'h0011 * 16'(i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, i[2:0], 16'h0000);
            e = exp_q.pop_front();
            total++;
            if (s_rvalid !== 1'b1 || s_dout !== e) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got rvalid=%b dout=%h, required rvalid=1 dout=%h", i, s_rvalid, s_dout, e);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        total++;
        if (s_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back_end: got rvalid=%b, required rvalid=0", s_rvalid);
        end
    endtask

    task automatic test_counter_wrap();
        logic [15:0] e;
        drive(1'b1, 1'b1, 3'd6, 16'hBEEF);
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b1, 3'd0, i[15:0]);
        end
        drive(1'b1, 1'b0, 3'd6, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_dout !== 16'h0000 || e !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_wcnt: got dout=%h, required dout=0000", s_dout);
        end
        drive(1'b1, 1'b0, 3'd7, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_dout !== 16'h0001 || e !== 16'h0001) begin
            bad++;
            $display("FAIL wrap_status: got dout=%h, required dout=0001", s_dout);
        end
        // STATUS is read-only: a write to it changes nothing.
        drive(1'b1, 1'b1, 3'd7, 16'hFFFF);
        drive(1'b1, 1'b0, 3'd7, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_dout !== 16'h0001 || e !== 16'h0001) begin
            bad++;
            $display("FAIL status_ro: got dout=%h, required dout=0001", s_dout);
        end
        drive(1'b1, 1'b0, 3'd6, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_dout !== 16'h0000 || e !== 16'h0000) begin
            bad++;
            $display("FAIL status_ro_wcnt: got dout=%h, required dout=0000", s_dout);
        end
        drive(1'b1, 1'b1, 3'd6, 16'h5555);
        drive(1'b1, 1'b0, 3'd6, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_dout !== 16'h0000 || e !== 16'h0000) begin
            bad++;
            $display("FAIL clear_wcnt: got dout=%h, required dout=0000", s_dout);
        end
        drive(1'b1, 1'b0, 3'd7, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_dout !== 16'h0000 || e !== 16'h0000) begin
            bad++;
            $display("FAIL clear_status: got dout=%h, required dout=0000", s_dout);
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        drive(1'b1, 1'b0, 3'd2, 16'h0000);
        e = exp_q.pop_front();
        total++;
        if (s_rvalid !== 1'b1 || s_dout !== 16'h0033 || e !== 16'h0033) begin
            bad++;
            $display("FAIL pre_reset_read: got rvalid=%b dout=%h, required rvalid=1 dout=0033", s_rvalid, s_dout);
        end
        s_sel = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (s_rvalid !== 1'b0 || s_dout !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset_drop: got rvalid=%b dout=%h, required rvalid=0 dout=0000", s_rvalid, s_dout);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 6; a++) begin
            drive(1'b1, 1'b0, a[2:0], 16'h0000);
            e = exp_q.pop_front();
            total++;
            if (s_rvalid !== 1'b1 || s_dout !== 16'h0000 || e !== 16'h0000) begin
                bad++;
                $display("FAIL post_reset_r%0d: got rvalid=%b dout=%h, required rvalid=1 dout=0000", a, s_rvalid, s_dout);
            end
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_counter_wrap();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
